// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoder fields and operands in, registered EX-side fields out.
// The master side is the decode/front-end; the slave side is the pipeline register.
interface id_ex_stage_if #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 3
);
    logic           id_valid;
    logic           id_regDst, id_branch, id_memRead, id_memToReg;
    logic           id_regWrite, id_ALUSrc, id_memWrite, id_sys;
    logic [OPW-1:0] id_ALUop;
    logic [RW-1:0]  id_rs, id_rt, id_rd;
    logic [DW-1:0]  id_rs_data, id_rt_data, id_imm, id_pc4;
    logic           ex_flush;

    logic           stall;
    logic           ex_valid;
    logic           ex_branch, ex_memRead, ex_memToReg, ex_regWrite;
    logic           ex_ALUSrc, ex_memWrite, ex_sys;
    logic [OPW-1:0] ex_ALUop;
    logic [RW-1:0]  ex_rs, ex_rt, ex_wreg;
    logic [DW-1:0]  ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic           halted;

    modport master (
        output id_valid, id_regDst, id_branch, id_memRead, id_memToReg,
               id_regWrite, id_ALUSrc, id_memWrite, id_sys, id_ALUop,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc4,
               ex_flush,
        input  stall, ex_valid, ex_branch, ex_memRead, ex_memToReg, ex_regWrite,
               ex_ALUSrc, ex_memWrite, ex_sys, ex_ALUop, ex_rs, ex_rt, ex_wreg,
               ex_rs_data, ex_rt_data, ex_imm, ex_pc4, halted
    );

    modport slave (
        input  id_valid, id_regDst, id_branch, id_memRead, id_memToReg,
               id_regWrite, id_ALUSrc, id_memWrite, id_sys, id_ALUop,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc4,
               ex_flush,
        output stall, ex_valid, ex_branch, ex_memRead, ex_memToReg, ex_regWrite,
               ex_ALUSrc, ex_memWrite, ex_sys, ex_ALUop, ex_rs, ex_rt, ex_wreg,
               ex_rs_data, ex_rt_data, ex_imm, ex_pc4, halted
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: load-use bubbles, branch flush,
// and a permanent front-end freeze once a SYSCALL has been captured into EX.
module id_ex_stage #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 3
) (
    input  logic          clk,
    input  logic          rst_b,
    id_ex_stage_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t         state_reg, state_next;
    logic           capture, stall_c, load_use, rt_is_source;
    logic [RW-1:0]  wreg_c;

    logic           ex_valid_reg, ex_branch_reg, ex_memRead_reg, ex_memToReg_reg;
    logic           ex_regWrite_reg, ex_ALUSrc_reg, ex_memWrite_reg, ex_sys_reg;
    logic [OPW-1:0] ex_ALUop_reg;
    logic [RW-1:0]  ex_rs_reg, ex_rt_reg, ex_wreg_reg;
    logic [DW-1:0]  ex_rs_data_reg, ex_rt_data_reg, ex_imm_reg, ex_pc4_reg;

    // rt is only a source for R-type, stores and branches; immediate forms overwrite it
    assign rt_is_source = ~bus.id_ALUSrc | bus.id_memWrite | bus.id_branch;
    assign load_use = ex_valid_reg & ex_memRead_reg & (ex_wreg_reg != '0) & bus.id_valid &
                      ((ex_wreg_reg == bus.id_rs) | ((ex_wreg_reg == bus.id_rt) & rt_is_source));

    // SYSCALL and non-writing instructions carry no destination into EX
    assign wreg_c = (bus.id_sys | ~bus.id_regWrite) ? '0 :
                    (bus.id_regDst ? bus.id_rd : bus.id_rt);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_reg <= RUN;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        stall_c    = 1'b0;
        case (state_reg)
            RUN: begin
                if (!bus.ex_flush) begin
                    if (load_use) begin
                        stall_c = 1'b1;
                    end else if (bus.id_valid) begin
                        capture = 1'b1;
                        if (bus.id_sys) state_next = HALT;
                    end
                end
            end
            HALT:    stall_c = 1'b1;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ex_valid_reg    <= 1'b0;
            ex_branch_reg   <= 1'b0;
            ex_memRead_reg  <= 1'b0;
            ex_memToReg_reg <= 1'b0;
            ex_regWrite_reg <= 1'b0;
            ex_ALUSrc_reg   <= 1'b0;
            ex_memWrite_reg <= 1'b0;
            ex_sys_reg      <= 1'b0;
            ex_ALUop_reg    <= '0;
            ex_wreg_reg     <= '0;
            ex_rs_reg       <= '0;
            ex_rt_reg       <= '0;
            ex_rs_data_reg  <= '0;
            ex_rt_data_reg  <= '0;
            ex_imm_reg      <= '0;
            ex_pc4_reg      <= '0;
        end else if (capture) begin
            // masking with ~id_sys keeps decoder X on SYSCALL out of the EX controls
            ex_valid_reg    <= 1'b1;
            ex_sys_reg      <= bus.id_sys;
            ex_branch_reg   <= bus.id_branch   & ~bus.id_sys;
            ex_memRead_reg  <= bus.id_memRead  & ~bus.id_sys;
            ex_memToReg_reg <= bus.id_memToReg & ~bus.id_sys;
            ex_regWrite_reg <= bus.id_regWrite & ~bus.id_sys;
            ex_ALUSrc_reg   <= bus.id_ALUSrc   & ~bus.id_sys;
            ex_memWrite_reg <= bus.id_memWrite & ~bus.id_sys;
            ex_ALUop_reg    <= bus.id_ALUop    & {OPW{~bus.id_sys}};
            ex_wreg_reg     <= wreg_c;
            ex_rs_reg       <= bus.id_rs;
            ex_rt_reg       <= bus.id_rt;
            ex_rs_data_reg  <= bus.id_rs_data;
            ex_rt_data_reg  <= bus.id_rt_data;
            ex_imm_reg      <= bus.id_imm;
            ex_pc4_reg      <= bus.id_pc4;
        end else begin
            // bubble: controls cleared, operand/index registers keep their last value
            ex_valid_reg    <= 1'b0;
            ex_sys_reg      <= 1'b0;
            ex_branch_reg   <= 1'b0;
            ex_memRead_reg  <= 1'b0;
            ex_memToReg_reg <= 1'b0;
            ex_regWrite_reg <= 1'b0;
            ex_ALUSrc_reg   <= 1'b0;
            ex_memWrite_reg <= 1'b0;
            ex_ALUop_reg    <= '0;
            ex_wreg_reg     <= '0;
        end
    end

    assign bus.stall       = stall_c;
    assign bus.halted      = (state_reg == HALT);
    assign bus.ex_valid    = ex_valid_reg;
    assign bus.ex_branch   = ex_branch_reg;
    assign bus.ex_memRead  = ex_memRead_reg;
    assign bus.ex_memToReg = ex_memToReg_reg;
    assign bus.ex_regWrite = ex_regWrite_reg;
    assign bus.ex_ALUSrc   = ex_ALUSrc_reg;
    assign bus.ex_memWrite = ex_memWrite_reg;
    assign bus.ex_sys      = ex_sys_reg;
    assign bus.ex_ALUop    = ex_ALUop_reg;
    assign bus.ex_rs       = ex_rs_reg;
    assign bus.ex_rt       = ex_rt_reg;
    assign bus.ex_wreg     = ex_wreg_reg;
    assign bus.ex_rs_data  = ex_rs_data_reg;
    assign bus.ex_rt_data  = ex_rt_data_reg;
    assign bus.ex_imm      = ex_imm_reg;
    assign bus.ex_pc4      = ex_pc4_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/SYSCALL scenarios plus random instruction
// streams, all compared every cycle against an instruction-level model of the EX slot.
module tb_id_ex_stage;
    localparam int DW = 32, RW = 5, OPW = 3;
    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_LUI = 5,
                   K_J = 6, K_SYS = 7, K_NOP = 8;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(DW), .RW(RW), .OPW(OPW)) bus();
    id_ex_stage #(.DW(DW), .RW(RW), .OPW(OPW)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    typedef struct {
        bit        valid, branch, mem_read, mem_to_reg, reg_write, alu_src, mem_write, sys;
        bit [2:0]  aluop;
        bit [4:0]  rs, rt, wreg;
        bit [31:0] rs_data, rt_data, imm, pc4;
    } slot_t;

    slot_t m;
    bit    m_halted;
    int    n_checks = 0, n_pass = 0, cyc = 0;
    bit    stalled;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // An EX load stalls ID when ID reads its nonzero destination as a source operand.
    function automatic bit model_hazard();
        bit reads_rt;
        reads_rt = !bus.id_ALUSrc || bus.id_memWrite || bus.id_branch;
        if (!(m.valid && m.mem_read && m.wreg != 0 && bus.id_valid)) return 1'b0;
        return (m.wreg == bus.id_rs) || (reads_rt && m.wreg == bus.id_rt);
    endfunction

    function automatic bit model_stall();
        return m_halted || (model_hazard() && !bus.ex_flush);
    endfunction

    task automatic model_edge();
        if (m_halted || bus.ex_flush || model_hazard() || !bus.id_valid) begin
            m.valid = 0; m.branch = 0; m.mem_read = 0; m.mem_to_reg = 0; m.reg_write = 0;
            m.alu_src = 0; m.mem_write = 0; m.sys = 0; m.aluop = 0; m.wreg = 0;
        end else begin
            m.valid = 1;
            m.rs = bus.id_rs; m.rt = bus.id_rt;
            m.rs_data = bus.id_rs_data; m.rt_data = bus.id_rt_data;
            m.imm = bus.id_imm; m.pc4 = bus.id_pc4;
            if (bus.id_sys) begin
                m.branch = 0; m.mem_read = 0; m.mem_to_reg = 0; m.reg_write = 0;
                m.alu_src = 0; m.mem_write = 0; m.sys = 1; m.aluop = 0; m.wreg = 0;
                m_halted = 1;
            end else begin
                m.branch = bus.id_branch; m.mem_read = bus.id_memRead;
                m.mem_to_reg = bus.id_memToReg; m.reg_write = bus.id_regWrite;
                m.alu_src = bus.id_ALUSrc; m.mem_write = bus.id_memWrite; m.sys = 0;
                m.aluop = bus.id_ALUop;
                m.wreg = !bus.id_regWrite ? 5'd0 : (bus.id_regDst ? bus.id_rd : bus.id_rt);
            end
        end
    endtask

    task automatic compare_all();
        check("stall", bus.stall, model_stall());
        check("halted", bus.halted, m_halted);
        check("ex_valid", bus.ex_valid, m.valid);
        check("ex_ctl", {bus.ex_branch, bus.ex_memRead, bus.ex_memToReg, bus.ex_regWrite,
                         bus.ex_ALUSrc, bus.ex_memWrite, bus.ex_sys},
              {m.branch, m.mem_read, m.mem_to_reg, m.reg_write, m.alu_src, m.mem_write, m.sys});
        check("ex_ALUop", bus.ex_ALUop, m.aluop);
        check("ex_wreg", bus.ex_wreg, m.wreg);
        if (m.valid) begin
            check("ex_rs", bus.ex_rs, m.rs);
            check("ex_rt", bus.ex_rt, m.rt);
            check("ex_rs_data", bus.ex_rs_data, m.rs_data);
            check("ex_rt_data", bus.ex_rt_data, m.rt_data);
            check("ex_imm", bus.ex_imm, m.imm);
            check("ex_pc4", bus.ex_pc4, m.pc4);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return just past the rising edge.
    task automatic step(input string what, output bit was_stalled);
        @(negedge clk);
        compare_all();
        was_stalled = model_stall();
        $display("cyc %0d %-8s id_valid=%0b flush=%0b stall=%0b ex_valid=%0b ex_wreg=%0d halted=%0b",
                 cyc, what, bus.id_valid, bus.ex_flush, bus.stall, bus.ex_valid, bus.ex_wreg, bus.halted);
        model_edge();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
        logic [2:0] r_ops [5];
        r_ops = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        bus.id_valid = 1; bus.id_sys = 0;
        bus.id_regDst = 0; bus.id_branch = 0; bus.id_memRead = 0; bus.id_memToReg = 0;
        bus.id_regWrite = 0; bus.id_ALUSrc = 0; bus.id_memWrite = 0; bus.id_ALUop = 3'b010;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
        bus.id_imm = $urandom; bus.id_pc4 = $urandom;
        case (kind)
            K_R:    begin bus.id_regDst = 1; bus.id_regWrite = 1;
                          bus.id_ALUop = r_ops[$urandom_range(0, 4)]; end
            K_LW:   begin bus.id_memRead = 1; bus.id_memToReg = 1; bus.id_regWrite = 1;
                          bus.id_ALUSrc = 1; end
            K_SW:   begin bus.id_ALUSrc = 1; bus.id_memWrite = 1; end
            K_BEQ:  begin bus.id_branch = 1; bus.id_ALUop = 3'b110; end
            K_ADDI: begin bus.id_ALUSrc = 1; bus.id_regWrite = 1; end
            K_LUI:  begin bus.id_ALUSrc = 1; bus.id_regWrite = 1; bus.id_ALUop = 3'b011; end
            K_SYS, K_NOP: begin
                // garbage controls stand in for the decoder's don't-care outputs
                {bus.id_regDst, bus.id_branch, bus.id_memRead, bus.id_memToReg,
                 bus.id_regWrite, bus.id_ALUSrc, bus.id_memWrite} = 7'($urandom);
                bus.id_ALUop = 3'($urandom);
                bus.id_sys = (kind == K_SYS);
                bus.id_valid = (kind == K_SYS);
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst_b = 0;
        #1;
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_ctl", {bus.ex_branch, bus.ex_memRead, bus.ex_memToReg, bus.ex_regWrite,
                          bus.ex_ALUSrc, bus.ex_memWrite, bus.ex_sys, bus.ex_ALUop}, 0);
        check("rst_wreg", bus.ex_wreg, 0);
        check("rst_data", bus.ex_rs_data | bus.ex_rt_data | bus.ex_imm | bus.ex_pc4, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_halted", bus.halted, 0);
        m = '{default: 0};
        m_halted = 0;
        bus.id_valid = 0; bus.ex_flush = 0;
        @(negedge clk);
        rst_b = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic peek_stall(input string tag, input bit exp);
        #1;
        check(tag, bus.stall, exp);
    endtask

    initial begin
        rst_b = 1;
        bus.ex_flush = 0;
        set_instr(K_NOP, 0, 0, 0);
        do_reset();

        // ADD $3,$1,$2 then reset mid-cycle while it sits in EX
        set_instr(K_R, 1, 2, 3); bus.id_ALUop = 3'b010;
        step("add", stalled);
        check("add_valid", bus.ex_valid, 1);
        check("add_aluop", bus.ex_ALUop, 3'b010);
        check("add_wreg", bus.ex_wreg, 3);
        #2;
        do_reset();

        // LW $5 ; ADD $6,$5,$2 -> one stall, bubble, then capture
        set_instr(K_LW, 1, 5, 0); step("lw", stalled);
        set_instr(K_R, 5, 2, 6); peek_stall("lu_add_stall", 1);
        step("add_hz", stalled);
        check("lu_bubble", bus.ex_valid, 0);
        peek_stall("lu_add_release", 0);
        step("add", stalled);
        check("lu_add_wreg", bus.ex_wreg, 6);

        // LW $5 ; SW $5 -> stall through rt
        set_instr(K_LW, 1, 5, 0); step("lw", stalled);
        set_instr(K_SW, 1, 5, 0); peek_stall("lu_sw_stall", 1);
        step("sw_hz", stalled);
        step("sw", stalled);

        // LW $5 ; ADDI $5,$1,4 -> rt is a destination only, no stall
        set_instr(K_LW, 1, 5, 0); step("lw", stalled);
        set_instr(K_ADDI, 1, 5, 0); peek_stall("lu_addi_nostall", 0);
        step("addi", stalled);

        // LW $0 ; use of $0 -> never a hazard
        set_instr(K_LW, 1, 0, 0); step("lw0", stalled);
        set_instr(K_R, 0, 0, 6); peek_stall("lu_r0_nostall", 0);
        step("add_r0", stalled);

        // load-use coinciding with flush -> flush wins
        set_instr(K_LW, 1, 5, 0); step("lw", stalled);
        set_instr(K_R, 5, 2, 6); bus.ex_flush = 1; peek_stall("flush_lu_stall", 0);
        step("flush_lu", stalled);
        check("flush_lu_valid", bus.ex_valid, 0);

        // BEQ killed by flush
        set_instr(K_BEQ, 1, 2, 0); bus.ex_flush = 1; peek_stall("flush_beq_stall", 0);
        step("flush_beq", stalled);
        check("flush_beq_branch", bus.ex_branch, 0);

        // SYSCALL coinciding with flush -> no halt
        set_instr(K_SYS, 0, 0, 0); step("flush_sys", stalled);
        check("flush_sys_halted", bus.halted, 0);
        bus.ex_flush = 0;

        // SYSCALL with garbage controls -> ex_sys one cycle, then frozen
        set_instr(K_SYS, 3, 4, 5); step("sys", stalled);
        check("sys_ex_sys", bus.ex_sys, 1);
        check("sys_ctl", {bus.ex_branch, bus.ex_memRead, bus.ex_memToReg, bus.ex_regWrite,
                          bus.ex_ALUSrc, bus.ex_memWrite, bus.ex_ALUop, bus.ex_wreg}, 0);
        for (int i = 0; i < 10; i++) begin
            set_instr(K_R, 1, 2, 3);
            bus.ex_flush = 1'($urandom);
            step("halted", stalled);
        end
        check("halt_hold", bus.halted, 1);
        do_reset();

        // random instruction streams; a stalled ID instruction is re-presented
        for (int seg = 0; seg < 4; seg++) begin
            stalled = 0;
            for (int i = 0; i < 150; i++) begin
                if (!stalled) begin
                    int r;
                    r = $urandom_range(0, 99);
                    if (r < 1)       set_instr(K_SYS, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 0);
                    else if (r < 10) set_instr(K_NOP, 0, 0, 0);
                    else             set_instr($urandom_range(0, 6), 5'($urandom_range(0, 7)),
                                               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                end
                bus.ex_flush = ($urandom_range(0, 99) < 15);
                step("rand", stalled);
            end
            do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
